// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the RV32M execute-stage sequencer: operand width,
// iteration count, funct_3 encodings, FSM state encoding and a small decode
// helper.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN         = 32;
    localparam int MULDIV_ITERS = 32;
    localparam int CNT_W        = 6;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // True for the four divide/remainder encodings.
    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl_if
// Pipeline <-> M-extension sequencer signal bundle.
//   master : pipeline side (drives start/flush/funct_3/rs1_val/rs2_val)
//   slave  : sequencer side (drives stall/busy/done/result)
// ---------------------------------------------------------------------------
interface ex_muldiv_ctrl_if;
    import muldiv_pkg::*;

    logic            start;
    logic            flush;
    logic [2:0]      funct_3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct_3, rs1_val, rs2_val,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, flush, funct_3, rs1_val, rs2_val,
        output stall, busy, done, result
    );

endinterface

// File: rtl/muldiv_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-division step: shift the next dividend bit
// (MSB of quo_in) into the partial remainder, trial-subtract the divisor and
// shift the resulting quotient bit into the bottom of the quotient.
//   rem_in/rem_out : partial remainder before/after the step
//   quo_in/quo_out : dividend bits still to consume / quotient bits produced
//   divisor        : divisor magnitude
// ---------------------------------------------------------------------------
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] partial;
    logic [XLEN:0] trial;

    always_comb begin
        partial = {rem_in, quo_in[XLEN-1]};
        trial   = partial - {1'b0, divisor};
        // A clear borrow bit means the divisor fits: keep the difference.
        if (!trial[XLEN]) begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = partial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ex_muldiv_ctrl
// Execute-stage sequencer for RV32M ops. Captures operand magnitudes, runs a
// serial shift-add multiplier or restoring divider for 32 iterations, applies
// sign correction, then presents the result with a one-cycle done pulse.
// Divide-by-zero and signed overflow bypass the datapath and finish in one
// cycle.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : ex_muldiv_ctrl_if.slave (start, flush, funct_3, rs1_val,
//                rs2_val in; stall, busy, done, result out)
// Build option: MULDIV_FAST_MUL_EN -- multiplies use one registered full
// product and skip the iterations (done two cycles after start).
// ---------------------------------------------------------------------------
module ex_muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    ex_muldiv_ctrl_if.slave bus
);

`ifdef MULDIV_FAST_MUL_EN
    localparam state_t MUL_ENTRY = ST_FIX;
`else
    localparam state_t MUL_ENTRY = ST_MUL;
`endif

    state_t            state_reg, state_next;
    logic              busy_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2*XLEN-1:0] acc_reg;     // product, or {unused, dividend/quotient}
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   opb_reg;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_reg;
    logic [2:0]        op_reg;
    logic              neg_q_reg;   // negate product / quotient
    logic              neg_r_reg;   // negate remainder (sign of dividend)

    // ---------------- load-time decode ----------------
    logic            accept, is_div, signed_a, signed_b, sign_a, sign_b;
    logic            div_zero, div_ovf, special, last_iter;
    logic [XLEN-1:0] mag_a, mag_b, special_val;

    always_comb begin
        accept   = (state_reg == ST_IDLE) && bus.start && !bus.flush;
        is_div   = is_div_op(bus.funct_3);
        // MUL only keeps the low word, which is sign-agnostic.
        signed_a = (bus.funct_3 == F3_MULH) || (bus.funct_3 == F3_MULHSU) ||
                   (bus.funct_3 == F3_DIV)  || (bus.funct_3 == F3_REM);
        signed_b = (bus.funct_3 == F3_MULH) || (bus.funct_3 == F3_DIV) ||
                   (bus.funct_3 == F3_REM);
        sign_a   = signed_a && bus.rs1_val[XLEN-1];
        sign_b   = signed_b && bus.rs2_val[XLEN-1];
        mag_a    = sign_a ? -bus.rs1_val : bus.rs1_val;
        mag_b    = sign_b ? -bus.rs2_val : bus.rs2_val;
        div_zero = is_div && (bus.rs2_val == '0);
        div_ovf  = ((bus.funct_3 == F3_DIV) || (bus.funct_3 == F3_REM)) &&
                   (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
        special  = div_zero || div_ovf;
        // funct_3[1] selects the remainder flavour of the divide ops.
        if (div_zero) begin
            special_val = bus.funct_3[1] ? bus.rs1_val : '1;
        end else begin
            special_val = bus.funct_3[1] ? '0 : INT_MIN;
        end
        last_iter = (cnt_reg == CNT_W'(MULDIV_ITERS - 1));
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_addend, mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem_next, div_quo_next;

    always_comb begin
        mul_addend = acc_reg[0] ? {1'b0, opb_reg} : '0;
        mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + mul_addend;
        mul_next   = {mul_sum, acc_reg[XLEN-1:1]};
    end

    muldiv_div_step u_div_step (
        .rem_in  (rem_reg),
        .quo_in  (acc_reg[XLEN-1:0]),
        .divisor (opb_reg),
        .rem_out (div_rem_next),
        .quo_out (div_quo_next)
    );

    // ---------------- sign correction / word select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo_fix  = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_fix  = neg_r_reg ? -rem_reg : rem_reg;
        case (op_reg)
            F3_MUL:                       fix_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quo_fix;
            default:                      fix_val = rem_fix;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (special)     state_next = ST_DONE;
                    else if (is_div) state_next = ST_DIV;
                    else             state_next = MUL_ENTRY;
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush)      state_next = ST_IDLE;
                else if (last_iter) state_next = ST_FIX;
            end
            ST_FIX:  state_next = bus.flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic done_int;

    always_comb begin
        done_int   = (state_reg == ST_DONE);
        // Released in the done cycle so EX/MEM captures the result.
        bus.stall  = (bus.start && (state_reg == ST_IDLE)) || (busy_reg && !done_int);
        bus.done   = done_int;
        bus.busy   = busy_reg;
        bus.result = result_reg;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg    <= bus.funct_3;
                        neg_q_reg <= sign_a ^ sign_b;
                        neg_r_reg <= sign_a;
                        cnt_reg   <= '0;
                        rem_reg   <= '0;
                        opb_reg   <= is_div ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
                        if (is_div) acc_reg <= {{XLEN{1'b0}}, mag_a};
                        else        acc_reg <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
                        acc_reg   <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
`endif
                        if (special) result_reg <= special_val;
                    end
                end
                ST_MUL: begin
                    acc_reg <= mul_next;
                    if (!last_iter) cnt_reg <= cnt_reg + 1'b1;
                end
                ST_DIV: begin
                    acc_reg[XLEN-1:0] <= div_quo_next;
                    rem_reg           <= div_rem_next;
                    if (!last_iter) cnt_reg <= cnt_reg + 1'b1;
                end
                ST_FIX: begin
                    // A flush here abandons the op, so the old result stays.
                    if (!bus.flush) result_reg <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_muldiv_ctrl_if bus();

    ex_muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit / integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 == F3_DIV || f3 == F3_DIVU || f3 == F3_REM || f3 == F3_REMU) begin
            if (b == 0) return 1;
            if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
            return DIV_LAT;
        end
        return MUL_LAT;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        last_result = 32'h0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold_start, input bit flush_done);
        int elat, lat, bad;
        elat = ref_lat(f3, a, b);
        bus.start   = 1'b1;
        bus.funct_3 = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        @(negedge clk);
        check("stall_on_start", bus.stall, 1);
        @(posedge clk);
        #1;
        if (!hold_start) begin
            bus.start = 1'b0;
        end else begin
            // operands change under a stale start; they must be ignored
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
        end
        lat = 0;
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            if (flush_done && k == elat) bus.flush = 1'b1;
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!(bus.stall && bus.busy)) bad++;
            @(posedge clk);
            #1;
        end
        check("latency", lat, elat);
        if (lat == 0) begin
            do_reset();
        end else begin
            check("result", bus.result, exp);
            check("stall_in_done", bus.stall, 0);
            check("busy_in_done", bus.busy, 1);
            check("stall_busy_wait", bad, 0);
            last_result = exp;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.flush = 1'b0;
            check("done_pulse", bus.done, 0);
            check("busy_after", bus.busy, 0);
            $display("op f3=%0d a=%08h b=%08h result=%08h lat=%0d hold=%0d fdone=%0d",
                     f3, a, b, exp, lat, hold_start, flush_done);
        end
    endtask

    task automatic run_flush(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input int k);
        int bad;
        bad = 0;
        bus.start   = 1'b1;
        bus.funct_3 = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c < k; c++) begin
            @(negedge clk);
            if (bus.done || !bus.busy) bad++;
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done) bad++;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_run", bad, 0);
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_result", bus.result, last_result);
        $display("flush f3=%0d a=%08h b=%08h at_cycle=%0d", f3, a, b, k);
    endtask

    task automatic run_start_flush(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.flush   = 1'b1;
        bus.funct_3 = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("sf_busy", bus.busy, 0);
        check("sf_done", bus.done, 0);
        check("sf_result", bus.result, last_result);
        $display("start+flush f3=%0d a=%08h b=%08h rejected", f3, a, b);
    endtask

    task automatic run_reset_mid();
        bus.start   = 1'b1;
        bus.funct_3 = F3_DIVU;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_stall", bus.stall, 0);
        reset = 1'b0;
        last_result = 32'h0;
        $display("reset mid-op applied at cycle N+5");
    endtask

    initial begin
        vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[7]  = '{F3_REMU,   32'd100,      32'd7,        32'd2};
        vecs[8]  = '{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{F3_REM,    32'd5,        32'd0,        32'd5};
        vecs[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0};
        vecs[12] = '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vecs[13] = '{F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1};
        vecs[14] = '{F3_REMU,   32'd3,        32'hFFFFFFFF, 32'd3};
        vecs[15] = '{F3_MULHU,  32'h80000000, 32'd2,        32'd1};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct_3 = 3'b000;
        bus.rs1_val = 32'h0;
        bus.rs2_val = 32'h0;
        last_result = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", bus.stall, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b0);
        end

        // flush in cycle N+10, then DIVU 9/3 started in the very next cycle
        run_flush(F3_DIV, 32'd100, 32'd7, 10);
        run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

        // flush during the done cycle: done still asserts
        run_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);

        // start held high while busy with changing operands
        run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b1, 1'b0);

        run_start_flush(F3_MUL, 32'd3, 32'd4);
        run_reset_mid();

        // randomized ops against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          mode, elat;
            f3   = 3'($urandom_range(0, 7));
            a    = pick();
            b    = pick();
            mode = $urandom_range(0, 9);
            elat = ref_lat(f3, a, b);
            if (mode < 6) begin
                run_op(f3, a, b, ref_result(f3, a, b), mode == 1, mode == 2);
            end else if (mode < 8 && elat > 1) begin
                run_flush(f3, a, b, $urandom_range(1, elat - 1));
            end else if (mode < 8) begin
                run_op(f3, a, b, ref_result(f3, a, b), 1'b0, 1'b0);
            end else begin
                run_start_flush(f3, a, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
